// File: rtl/pico_pkg.sv
// pico_pkg: opcode/state encodings and ROM-word field positions for the picoMips sequencer.
package pico_pkg;
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LDR  = 4'h2,
        OP_LDSW = 4'h3,
        OP_ADDI = 4'h4,
        OP_ADDR = 4'h5,
        OP_MULI = 4'h6,
        OP_STR  = 4'h7,
        OP_JMP  = 4'h8,
        OP_BZ   = 4'h9,
        OP_WBTN = 4'hA,
        OP_HALT = 4'hB
    } opcode_t;
    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_HALT
    } state_t;
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
endpackage

// File: rtl/pico_decode.sv
// pico_decode: combinational opcode to ALU/register-file control decode; opcodes 0xC-0xF decode as NOP.
module pico_decode
    import pico_pkg::*;
(
    input  opcode_t i_op,
    output logic    o_we,
    output logic    o_sel_sw,
    output logic    o_sel_imm,
    output logic    o_use_mul,
    output logic    o_use_acc,
    output logic    o_reg_we
);
    assign o_we      = i_op inside {OP_LDI, OP_LDR, OP_LDSW, OP_ADDI, OP_ADDR, OP_MULI};
    assign o_sel_sw  = i_op == OP_LDSW;
    assign o_sel_imm = i_op inside {OP_LDI, OP_ADDI, OP_MULI};
    assign o_use_mul = i_op == OP_MULI;
    assign o_use_acc = i_op inside {OP_ADDI, OP_ADDR, OP_MULI};
    assign o_reg_we  = i_op == OP_STR;
endmodule

// File: rtl/pico_ctrl.sv
// pico_ctrl: picoMips sequencer - PC, branches, WBTN wait handshake, HALT and gated control strobes.
// Define PICO_BTN_SYNC_EN to pass the push button through a 2-flop synchroniser.
module pico_ctrl
    import pico_pkg::*;
#(
    parameter int PC_WIDTH = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [15:0]         i_instr,
    input  logic [7:0]          i_acc,
    input  logic                i_btn,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [7:0]          o_imm,
    output logic [3:0]          o_reg_addr,
    output logic [2:0]          o_func,
    output logic                o_we,
    output logic                o_sel_sw,
    output logic                o_sel_imm,
    output logic                o_use_mul,
    output logic                o_use_acc,
    output logic                o_reg_we,
    output logic                o_halted
);
    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                w_btn;
    logic                w_run;
    logic                w_we, w_sel_sw, w_sel_imm, w_use_mul, w_use_acc, w_reg_we;
    opcode_t             w_op;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_target;

    assign w_op     = opcode_t'(i_instr[OP_HI:OP_LO]);
    assign w_pc_inc = r_pc + PC_WIDTH'(1);
    assign w_target = i_instr[IMM_LO +: PC_WIDTH];

`ifdef PICO_BTN_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge i_clock) begin
        if (i_reset) r_sync <= '0;
        else         r_sync <= {r_sync[0], i_btn};
    end
    assign w_btn = r_sync[1];
`else
    assign w_btn = i_btn;
`endif

    pico_decode u_decode (
        .i_op      (w_op),
        .o_we      (w_we),
        .o_sel_sw  (w_sel_sw),
        .o_sel_imm (w_sel_imm),
        .o_use_mul (w_use_mul),
        .o_use_acc (w_use_acc),
        .o_reg_we  (w_reg_we)
    );

    // Reset also masks strobes so a reset cycle never writes ACC or the register file.
    assign w_run      = (r_state == S_RUN) && !i_reset;
    assign o_we       = w_run & w_we;
    assign o_sel_sw   = w_run & w_sel_sw;
    assign o_sel_imm  = w_run & w_sel_imm;
    assign o_use_mul  = w_run & w_use_mul;
    assign o_use_acc  = w_run & w_use_acc;
    assign o_reg_we   = w_run & w_reg_we;
    assign o_imm      = i_instr[IMM_HI:IMM_LO];
    assign o_reg_addr = i_instr[RD_HI:RD_LO];
    assign o_func     = i_instr[OP_LO+2:OP_LO];
    assign o_pc       = r_pc;
    assign o_halted   = r_state == S_HALT;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_RUN;
            r_pc    <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    case (w_op)
                        OP_JMP:  r_pc <= w_target;
                        OP_BZ:   r_pc <= (i_acc == 8'h00) ? w_target : w_pc_inc;
                        OP_WBTN: r_state <= S_WAIT_PRESS;
                        OP_HALT: r_state <= S_HALT;
                        default: r_pc <= w_pc_inc;
                    endcase
                end
                S_WAIT_PRESS: if (w_btn) r_state <= S_WAIT_RELEASE;
                S_WAIT_RELEASE: begin
                    if (!w_btn) begin
                        r_state <= S_RUN;
                        r_pc    <= w_pc_inc;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_pico_ctrl.sv
// tb_pico_ctrl: directed self-checking bench for pico_ctrl (default and PICO_BTN_SYNC_EN builds).
module tb_pico_ctrl;
`ifdef PICO_BTN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [7:0]  acc;
    logic        btn;
    logic [4:0]  pc;
    logic [7:0]  imm;
    logic [3:0]  reg_addr;
    logic [2:0]  func;
    logic        we, sel_sw, sel_imm, use_mul, use_acc, reg_we, halted;
    int          n_vec = 0;
    int          n_err = 0;
    logic [5:0]  ctl_exp [16];

    pico_ctrl #(.PC_WIDTH(5)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_instr    (instr),
        .i_acc      (acc),
        .i_btn      (btn),
        .o_pc       (pc),
        .o_imm      (imm),
        .o_reg_addr (reg_addr),
        .o_func     (func),
        .o_we       (we),
        .o_sel_sw   (sel_sw),
        .o_sel_imm  (sel_imm),
        .o_use_mul  (use_mul),
        .o_use_acc  (use_acc),
        .o_reg_we   (reg_we),
        .o_halted   (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] im);
        return {op, rd, im};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ctl();
        return {we, sel_sw, sel_imm, use_mul, use_acc, reg_we};
    endfunction

    initial begin
        // {we, sel_sw, sel_imm, use_mul, use_acc, reg_we} per opcode
        ctl_exp = '{6'b000000, 6'b101000, 6'b100000, 6'b110000, 6'b101010, 6'b100010,
                    6'b101110, 6'b000001, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                    6'b000000, 6'b000000, 6'b000000, 6'b000000};
        rst = 1'b1; instr = ins(4'h1, 4'h0, 8'h05); acc = 8'h00; btn = 1'b0;
        tick(); tick();
        chk("rst_pc", 16'(pc), 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_we", 16'(we), 16'h0);
        rst = 1'b0; #1;
        chk("run0_we", 16'(we), 16'h1);
        chk("run0_selimm", 16'(sel_imm), 16'h1);
        chk("run0_imm", 16'(imm), 16'h05);
        tick();
        chk("pc_inc", 16'(pc), 16'h1);
        for (int i = 0; i < 16; i++) begin
            instr = ins(4'(i), 4'hA, 8'h3C); #1;
            chk($sformatf("dec_op%0h", i), 16'(ctl()), 16'(ctl_exp[i]));
        end
        chk("regaddr", 16'(reg_addr), 16'hA);
        chk("func", 16'(func), 16'h7);
        instr = ins(4'h9, 4'h0, 8'h0C); acc = 8'h00; tick();
        chk("bz_taken", 16'(pc), 16'h0C);
        acc = 8'h01; tick();
        chk("bz_not_taken", 16'(pc), 16'h0D);
        instr = ins(4'h8, 4'h0, 8'hE3); tick();
        chk("jmp_trunc", 16'(pc), 16'h03);
        instr = ins(4'hA, 4'h0, 8'h00); tick();
        instr = ins(4'h1, 4'h0, 8'h11);
        for (int i = 0; i < 10; i++) tick();
        chk("wbtn_hold_pc", 16'(pc), 16'h3);
        chk("wbtn_no_strobe", 16'(ctl()), 16'h0);
        btn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("wbtn_pressed_pc", 16'(pc), 16'h3);
        btn = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("wbtn_rel_edge%0d", i), 16'(pc), (i <= LAT) ? 16'h3 : 16'(4 + i - LAT - 1));
        end
        chk("wbtn_resume_we", 16'(we), 16'h1);
        instr = ins(4'h8, 4'h0, 8'h1F); tick();
        chk("jmp_1f", 16'(pc), 16'h1F);
        instr = ins(4'h0, 4'h0, 8'h00); tick();
        chk("pc_wrap", 16'(pc), 16'h00);
        instr = ins(4'h8, 4'h0, 8'h07); tick();
        chk("jmp_7", 16'(pc), 16'h07);
        instr = ins(4'hB, 4'h0, 8'h00); tick();
        chk("halt_flag", 16'(halted), 16'h1);
        for (int i = 0; i < 20; i++) begin
            instr = ins(4'(i), 4'h0, 8'(i * 5)); btn = 1'(i); acc = 8'h00; tick();
            chk($sformatf("halt_pc%0d", i), 16'(pc), 16'h07);
            chk($sformatf("halt_ctl%0d", i), 16'({halted, ctl()}), 16'h40);
        end
        rst = 1'b1; tick(); rst = 1'b0; btn = 1'b0; #1;
        chk("halt_rst_pc", 16'(pc), 16'h0);
        chk("halt_rst_flag", 16'(halted), 16'h0);
        instr = ins(4'hA, 4'h0, 8'h00); tick();
        instr = ins(4'h1, 4'h0, 8'h22); btn = 1'b1;
        for (int i = 0; i <= LAT; i++) tick();
        chk("midwait_pc", 16'(pc), 16'h0);
        chk("midwait_we", 16'(we), 16'h0);
        instr = ins(4'h7, 4'h2, 8'h00); rst = 1'b1; #1;
        chk("midwait_rst_ctl", 16'(ctl()), 16'h0);
        tick();
        chk("midwait_rst_ctl2", 16'(ctl()), 16'h0);
        rst = 1'b0; #1;
        chk("midwait_run_pc", 16'(pc), 16'h0);
        chk("midwait_run_regwe", 16'(reg_we), 16'h1);
        chk("midwait_run_halted", 16'(halted), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
